// File: rtl/exchange_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// exchange_ctrl_pkg
// Shared definitions for the exchange-side call controller and the card
// billing block: call-state encoding, category codes and the first-digit
// classifier.
// ---------------------------------------------------------------------------
package exchange_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DIAL_TONE,
    DIALING,
    RINGING,
    CONNECTED,
    BUSY
  } state_t;

  typedef logic [1:0] cat_t;

  localparam cat_t CAT_NONE    = 2'b00;
  localparam cat_t CAT_LOCAL   = 2'b01;
  localparam cat_t CAT_LONG    = 2'b10;
  localparam cat_t CAT_SPECIAL = 2'b11;

  // Only decimal digits are dialable; codes A-F are line noise.
  function automatic logic is_bcd(input logic [3:0] d);
    return (d <= 4'd9);
  endfunction

  // Leading 0 means long distance, leading 1 a service number.
  function automatic cat_t classify(input logic [3:0] d);
    if (d == 4'd0)      return CAT_LONG;
    else if (d == 4'd1) return CAT_SPECIAL;
    else                return CAT_LOCAL;
  endfunction

endpackage

// File: rtl/exchange_ctrl_if.sv
// ---------------------------------------------------------------------------
// exchange_ctrl_if
// Handset / billing-side signal bundle of the exchange controller.
//   offhook, digit_valid, digit, answer, card, cut : toward the controller
//   on, category, dial_tone, ring_back, busy_tone  : from the controller
// slave  : seen by exchange_ctrl
// master : seen by whatever drives the handset and billing inputs
// ---------------------------------------------------------------------------
interface exchange_ctrl_if;
  import exchange_ctrl_pkg::*;

  logic       offhook;
  logic       digit_valid;
  logic [3:0] digit;
  logic       answer;
  logic       card;
  logic       cut;
  logic       on;
  cat_t       category;
  logic       dial_tone;
  logic       ring_back;
  logic       busy_tone;

  modport slave (
    input  offhook, digit_valid, digit, answer, card, cut,
    output on, category, dial_tone, ring_back, busy_tone
  );

  modport master (
    output offhook, digit_valid, digit, answer, card, cut,
    input  on, category, dial_tone, ring_back, busy_tone
  );

endinterface

// File: rtl/exchange_ctrl_digit_collector.sv
// ---------------------------------------------------------------------------
// digit_collector
// Counts dialed digits, latches the category from the first digit and owns
// the shared tick counter (inter-digit timeout here, ring-back timeout in
// the parent).
// Ports:
//   clk_4Hz, clrn  : tick clock, async active-low reset
//   first          : parent is in DIAL_TONE (next digit is the first)
//   collect        : parent is in DIALING
//   digit_valid/digit : dial strobe and BCD value
//   cnt_clr        : parent changes state this edge
//   cat_clr        : parent goes to IDLE this edge
//   accept         : a usable digit is being consumed this edge
//   complete       : this digit finishes the number
//   timeout        : digit wait expired this edge
//   category       : latched category
//   ticks          : current tick counter value
// ---------------------------------------------------------------------------
module digit_collector
  import exchange_ctrl_pkg::*;
#(
  parameter int NUM_LOCAL   = 7,
  parameter int NUM_LONG    = 11,
  parameter int NUM_SPECIAL = 3,
  parameter int DIGIT_TICKS = 40,
  parameter int CNT_W       = 8
) (
  input  logic             clk_4Hz,
  input  logic             clrn,
  input  logic             first,
  input  logic             collect,
  input  logic             digit_valid,
  input  logic [3:0]       digit,
  input  logic             cnt_clr,
  input  logic             cat_clr,
  output logic             accept,
  output logic             complete,
  output logic             timeout,
  output cat_t             category,
  output logic [CNT_W-1:0] ticks
);

  logic [3:0]       count_q, count_d;
  cat_t             cat_q, cat_d;
  logic [CNT_W-1:0] ticks_q, ticks_d;
  logic [3:0]       target;

  always_comb begin
    case (cat_q)
      CAT_LONG:    target = 4'(NUM_LONG);
      CAT_SPECIAL: target = 4'(NUM_SPECIAL);
      default:     target = 4'(NUM_LOCAL);
    endcase
  end

  assign accept   = digit_valid && is_bcd(digit) && (first || collect);
  assign complete = collect && accept && ((count_q + 4'd1) == target);
  // The counter value includes the current edge, so expiry fires when
  // the previous value is one short; a digit on the same edge wins.
  assign timeout  = (first || collect) && !accept &&
                    (ticks_q >= CNT_W'(DIGIT_TICKS - 1));

  always_comb begin
    count_d = count_q;
    cat_d   = cat_q;
    ticks_d = (&ticks_q) ? ticks_q : ticks_q + 1'b1;
    if (accept) begin
      ticks_d = '0;
      count_d = first ? 4'd1 : count_q + 4'd1;
      if (first) cat_d = classify(digit);
    end
    if (cnt_clr) ticks_d = '0;
    if (cat_clr) begin
      cat_d   = CAT_NONE;
      count_d = '0;
    end
  end

  always_ff @(posedge clk_4Hz or negedge clrn) begin
    if (!clrn) begin
      count_q <= '0;
      cat_q   <= CAT_NONE;
      ticks_q <= '0;
    end else begin
      count_q <= count_d;
      cat_q   <= cat_d;
      ticks_q <= ticks_d;
    end
  end

  assign category = cat_q;
  assign ticks    = ticks_q;

endmodule

// File: rtl/exchange_ctrl.sv
// ---------------------------------------------------------------------------
// exchange_ctrl
// Exchange-side call controller: tracks the handset, collects digits, runs
// ring-back, holds the connection and tears it down on hang-up, cut, card
// removal or timeout. Drives on/category for the billing block.
// Ports:
//   clk_4Hz : 4 Hz tick clock, rising edge
//   clrn    : asynchronous active-low reset
//   bus     : exchange_ctrl_if.slave (handset, billing and tone signals)
// ---------------------------------------------------------------------------
module exchange_ctrl
  import exchange_ctrl_pkg::*;
#(
  parameter int NUM_LOCAL   = 7,
  parameter int NUM_LONG    = 11,
  parameter int NUM_SPECIAL = 3,
  parameter int RING_TICKS  = 20,
  parameter int DIGIT_TICKS = 40,
  parameter int CNT_W       = 8
) (
  input  logic           clk_4Hz,
  input  logic           clrn,
  exchange_ctrl_if.slave bus
);

  state_t           state_q, state_d;
  logic             on_q, on_d;
  logic             dial_tone_q, dial_tone_d;
  logic             ring_back_q, ring_back_d;
  logic             busy_tone_q, busy_tone_d;

  logic             accept, complete, timeout;
  cat_t             category;
  logic [CNT_W-1:0] ticks;

  digit_collector #(
    .NUM_LOCAL   (NUM_LOCAL),
    .NUM_LONG    (NUM_LONG),
    .NUM_SPECIAL (NUM_SPECIAL),
    .DIGIT_TICKS (DIGIT_TICKS),
    .CNT_W       (CNT_W)
  ) u_digits (
    .clk_4Hz     (clk_4Hz),
    .clrn        (clrn),
    .first       (state_q == DIAL_TONE),
    .collect     (state_q == DIALING),
    .digit_valid (bus.digit_valid),
    .digit       (bus.digit),
    .cnt_clr     (state_d != state_q),
    .cat_clr     (state_d == IDLE),
    .accept      (accept),
    .complete    (complete),
    .timeout     (timeout),
    .category    (category),
    .ticks       (ticks)
  );

  // Outputs are registered from the next state so they change on the
  // same edge as the state itself.
  always_ff @(posedge clk_4Hz or negedge clrn) begin
    if (!clrn) begin
      state_q     <= IDLE;
      on_q        <= 1'b0;
      dial_tone_q <= 1'b0;
      ring_back_q <= 1'b0;
      busy_tone_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      on_q        <= on_d;
      dial_tone_q <= dial_tone_d;
      ring_back_q <= ring_back_d;
      busy_tone_q <= busy_tone_d;
    end
  end

  // Hang-up is applied last so it overrides every other condition.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (bus.offhook) state_d = DIAL_TONE;
      DIAL_TONE: begin
        if (accept)       state_d = DIALING;
        else if (timeout) state_d = BUSY;
      end
      DIALING: begin
        if (complete)
          state_d = (bus.card || category == CAT_SPECIAL) ? RINGING : BUSY;
        else if (timeout)
          state_d = BUSY;
      end
      RINGING: begin
        if (bus.answer)                             state_d = CONNECTED;
        else if (ticks >= CNT_W'(RING_TICKS - 1))   state_d = BUSY;
      end
      CONNECTED: begin
        if (bus.cut)                                      state_d = BUSY;
        else if (!bus.card && category != CAT_SPECIAL)    state_d = BUSY;
        else if (!bus.answer)                             state_d = BUSY;
      end
      BUSY:      state_d = BUSY;
      default:   state_d = IDLE;
    endcase
    if (!bus.offhook) state_d = IDLE;
  end

  always_comb begin
    on_d        = (state_d == CONNECTED);
    dial_tone_d = (state_d == DIAL_TONE);
    ring_back_d = (state_d == RINGING);
    busy_tone_d = (state_d == BUSY);
  end

  assign bus.on        = on_q;
  assign bus.category  = category;
  assign bus.dial_tone = dial_tone_q;
  assign bus.ring_back = ring_back_q;
  assign bus.busy_tone = busy_tone_q;

endmodule

// File: tb/tb_exchange_ctrl.sv
// ---------------------------------------------------------------------------
// tb_exchange_ctrl
// Directed bench for exchange_ctrl: call setup, ring timeout, category
// handling, cut, digit timeouts, invalid digits and mid-call reset.
// ---------------------------------------------------------------------------
module tb_exchange_ctrl;
  import exchange_ctrl_pkg::*;

  localparam int RING_T  = 20;
  localparam int DIGIT_T = 40;

  logic clk_4Hz;
  logic clrn;
  int   total = 0;
  int   bad   = 0;

  exchange_ctrl_if bus();

  exchange_ctrl dut (
    .clk_4Hz (clk_4Hz),
    .clrn    (clrn),
    .bus     (bus.slave)
  );

  initial begin
    clk_4Hz = 1'b0;
    forever #5 clk_4Hz = ~clk_4Hz;
  end

  task automatic tick();
    @(posedge clk_4Hz);
    #1;
  endtask

  task automatic dial(input logic [3:0] d);
    bus.digit_valid = 1'b1;
    bus.digit       = d;
    tick();
    bus.digit_valid = 1'b0;
    bus.digit       = 4'd0;
  endtask

  task automatic hang_up();
    bus.offhook = 1'b0;
    bus.answer  = 1'b0;
    bus.cut     = 1'b0;
    tick();
  endtask

  task automatic dial_long();
    logic [3:0] num [11] = '{4'd0, 4'd1, 4'd0, 4'd6, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8};
    for (int i = 0; i < 11; i++) dial(num[i]);
  endtask

  task automatic dial_local();
    logic [3:0] num [7] = '{4'd2, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6};
    for (int i = 0; i < 7; i++) dial(num[i]);
  endtask

  task automatic test_reset();
    logic [5:0] outs;
    clrn = 1'b0;
    bus.offhook = 1'b0; bus.digit_valid = 1'b0; bus.digit = 4'd0;
    bus.answer = 1'b0; bus.card = 1'b0; bus.cut = 1'b0;
    #12;
    outs = {bus.on, bus.category, bus.dial_tone, bus.ring_back, bus.busy_tone};
    total++;
    if (outs !== 6'b0) begin bad++; $display("[TB] FAIL reset_outs got=%b exp=000000", outs); end
    clrn = 1'b1;
    tick();
    outs = {bus.on, bus.category, bus.dial_tone, bus.ring_back, bus.busy_tone};
    total++;
    if (outs !== 6'b0) begin bad++; $display("[TB] FAIL idle_outs got=%b exp=000000", outs); end
  endtask

  task automatic test_long_call();
    logic [3:0] num [11] = '{4'd0, 4'd1, 4'd0, 4'd6, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8};
    bus.card = 1'b1; bus.offhook = 1'b1;
    tick();
    total++;
    if (bus.dial_tone !== 1'b1) begin bad++; $display("[TB] FAIL t1_dial_tone got=%b exp=1", bus.dial_tone); end
    dial(num[0]);
    total++;
    if (bus.category !== CAT_LONG || bus.dial_tone !== 1'b0) begin
      bad++; $display("[TB] FAIL t1_first_digit cat=%b tone=%b exp cat=10 tone=0", bus.category, bus.dial_tone);
    end
    for (int i = 1; i < 11; i++) dial(num[i]);
    for (int i = 0; i < 3; i++) begin
      total++;
      if (bus.ring_back !== 1'b1 || bus.on !== 1'b0) begin
        bad++; $display("[TB] FAIL t1_ring%0d ring=%b on=%b exp ring=1 on=0", i, bus.ring_back, bus.on);
      end
      if (i < 2) tick();
    end
    bus.answer = 1'b1;
    tick();
    total++;
    if (bus.on !== 1'b1 || bus.ring_back !== 1'b0 || bus.category !== CAT_LONG) begin
      bad++; $display("[TB] FAIL t1_connect on=%b ring=%b cat=%b exp on=1 ring=0 cat=10", bus.on, bus.ring_back, bus.category);
    end
    hang_up();
    total++;
    if (bus.on !== 1'b0 || bus.category !== CAT_NONE) begin
      bad++; $display("[TB] FAIL t1_hangup on=%b cat=%b exp on=0 cat=00", bus.on, bus.category);
    end
  endtask

  task automatic test_ring_timeout();
    logic [3:0] num [7] = '{4'd5, 4'd5, 4'd5, 4'd1, 4'd2, 4'd3, 4'd4};
    int  ring_cnt;
    logic on_seen;
    bus.card = 1'b1; bus.answer = 1'b0; bus.offhook = 1'b1;
    tick();
    for (int i = 0; i < 7; i++) dial(num[i]);
    ring_cnt = 0;
    on_seen  = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.on) on_seen = 1'b1;
      if (!bus.ring_back) break;
      ring_cnt++;
      tick();
    end
    total++;
    if (ring_cnt != RING_T) begin bad++; $display("[TB] FAIL t2_ring_len got=%0d exp=%0d", ring_cnt, RING_T); end
    total++;
    if (bus.busy_tone !== 1'b1 || on_seen !== 1'b0) begin
      bad++; $display("[TB] FAIL t2_busy busy=%b on_seen=%b exp busy=1 on_seen=0", bus.busy_tone, on_seen);
    end
    hang_up();
    total++;
    if (bus.busy_tone !== 1'b0 || bus.dial_tone !== 1'b0) begin
      bad++; $display("[TB] FAIL t2_idle busy=%b tone=%b exp 0 0", bus.busy_tone, bus.dial_tone);
    end
  endtask

  task automatic test_category();
    bus.card = 1'b0; bus.offhook = 1'b1;
    tick();
    dial(4'd1); dial(4'd1); dial(4'd0);
    total++;
    if (bus.ring_back !== 1'b1 || bus.category !== CAT_SPECIAL) begin
      bad++; $display("[TB] FAIL t3_special_ring ring=%b cat=%b exp ring=1 cat=11", bus.ring_back, bus.category);
    end
    bus.answer = 1'b1;
    tick();
    tick();
    total++;
    if (bus.on !== 1'b1) begin bad++; $display("[TB] FAIL t3_special_on got=%b exp=1", bus.on); end
    hang_up();
    bus.offhook = 1'b1;
    tick();
    dial_local();
    total++;
    if (bus.busy_tone !== 1'b1 || bus.category !== CAT_LOCAL || bus.on !== 1'b0) begin
      bad++; $display("[TB] FAIL t3_nocard busy=%b cat=%b on=%b exp busy=1 cat=01 on=0", bus.busy_tone, bus.category, bus.on);
    end
    hang_up();
  endtask

  task automatic test_cut();
    bus.card = 1'b1; bus.offhook = 1'b1;
    tick();
    dial_local();
    bus.answer = 1'b1;
    tick();
    total++;
    if (bus.on !== 1'b1) begin bad++; $display("[TB] FAIL t4_on got=%b exp=1", bus.on); end
    bus.cut = 1'b1;
    tick();
    bus.cut = 1'b0;
    total++;
    if (bus.on !== 1'b0 || bus.busy_tone !== 1'b1 || bus.category !== CAT_LOCAL) begin
      bad++; $display("[TB] FAIL t4_cut on=%b busy=%b cat=%b exp on=0 busy=1 cat=01", bus.on, bus.busy_tone, bus.category);
    end
    tick(); tick();
    total++;
    if (bus.category !== CAT_LOCAL || bus.on !== 1'b0) begin
      bad++; $display("[TB] FAIL t4_hold cat=%b on=%b exp cat=01 on=0", bus.category, bus.on);
    end
    hang_up();
    total++;
    if (bus.category !== CAT_NONE) begin bad++; $display("[TB] FAIL t4_clear cat=%b exp=00", bus.category); end
  endtask

  task automatic test_timeouts();
    int n;
    bus.card = 1'b1; bus.answer = 1'b0; bus.offhook = 1'b1;
    tick();
    n = 0;
    for (int i = 0; i < 60 && bus.dial_tone; i++) begin n++; tick(); end
    total++;
    if (n != DIGIT_T || bus.busy_tone !== 1'b1) begin
      bad++; $display("[TB] FAIL t5_first_digit len=%0d busy=%b exp len=%0d busy=1", n, bus.busy_tone, DIGIT_T);
    end
    hang_up();
    bus.offhook = 1'b1;
    tick();
    dial(4'd2); dial(4'd3);
    n = 0;
    for (int i = 0; i < 60 && !bus.busy_tone; i++) begin n++; tick(); end
    total++;
    if (n != DIGIT_T) begin bad++; $display("[TB] FAIL t5_inter_digit len=%0d exp=%0d", n, DIGIT_T); end
    hang_up();
  endtask

  task automatic test_bad_digit();
    bus.card = 1'b1; bus.answer = 1'b0; bus.offhook = 1'b1;
    tick();
    dial(4'd2); dial(4'd3); dial(4'd4); dial(4'd5); dial(4'd6); dial(4'd7);
    dial(4'hA);
    total++;
    if (bus.ring_back !== 1'b0 || bus.busy_tone !== 1'b0) begin
      bad++; $display("[TB] FAIL t5_hex_count ring=%b busy=%b exp 0 0", bus.ring_back, bus.busy_tone);
    end
    dial(4'd8);
    total++;
    if (bus.ring_back !== 1'b1) begin bad++; $display("[TB] FAIL t5_complete_after_hex ring=%b exp=1", bus.ring_back); end
    hang_up();
    bus.offhook = 1'b1;
    tick();
    dial(4'd2);
    repeat (19) tick();
    dial(4'hA);
    repeat (19) tick();
    total++;
    if (bus.busy_tone !== 1'b0) begin bad++; $display("[TB] FAIL t5_hex_early busy=%b exp=0", bus.busy_tone); end
    tick();
    total++;
    if (bus.busy_tone !== 1'b1) begin bad++; $display("[TB] FAIL t5_hex_no_reset busy=%b exp=1", bus.busy_tone); end
    hang_up();
  endtask

  task automatic test_reset_midcall();
    bus.card = 1'b1; bus.offhook = 1'b1;
    tick();
    dial_long();
    bus.answer = 1'b1;
    tick();
    total++;
    if (bus.on !== 1'b1 || bus.category !== CAT_LONG) begin
      bad++; $display("[TB] FAIL t6_on on=%b cat=%b exp on=1 cat=10", bus.on, bus.category);
    end
    #2 clrn = 1'b0;
    #1;
    total++;
    if (bus.on !== 1'b0 || bus.category !== CAT_NONE) begin
      bad++; $display("[TB] FAIL t6_async on=%b cat=%b exp on=0 cat=00", bus.on, bus.category);
    end
    #1 clrn = 1'b1;
    tick();
    total++;
    if (bus.dial_tone !== 1'b1) begin bad++; $display("[TB] FAIL t6_after_reset tone=%b exp=1", bus.dial_tone); end
    hang_up();
    bus.offhook = 1'b1; bus.card = 1'b1;
    tick();
    dial_long();
    bus.answer = 1'b1;
    tick();
    bus.card = 1'b0;
    tick();
    total++;
    if (bus.on !== 1'b0 || bus.busy_tone !== 1'b1 || bus.category !== CAT_LONG) begin
      bad++; $display("[TB] FAIL t6_card_out on=%b busy=%b cat=%b exp on=0 busy=1 cat=10", bus.on, bus.busy_tone, bus.category);
    end
    hang_up();
  endtask

  initial begin
    test_reset();
    test_long_call();
    test_ring_timeout();
    test_category();
    test_cut();
    test_timeouts();
    test_bad_digit();
    test_reset_midcall();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/exchange_ctrl.md
Name: exchange_ctrl

Overview:
Exchange-side call controller: the far end of the billing interface. It generates `on` and `category` for the card billing block and consumes that block's `cut` and `read` outputs.
Tracks handset state, collects dialed BCD digits and classifies the call from the first digit. It then runs ring-back, holds the connection, and tears the call down on hang-up, cut, card removal or timeout.
Sits beside the billing block in the top level and is clocked from the same 4 Hz divider output.

Parameters:
NUM_LOCAL, 7, digit count completing a local number
NUM_LONG, 11, digit count completing a long-distance number (includes leading 0)
NUM_SPECIAL, 3, digit count completing a special/service number (leading 1)
RING_TICKS, 20, clk_4Hz ticks of ring-back before no-answer (5 s)
DIGIT_TICKS, 40, max ticks between digits, or before the first digit (10 s)
CNT_W, 8, width of the shared tick counter; must hold max(RING_TICKS, DIGIT_TICKS)

Ports:
clk_4Hz  in  1  system tick clock, rising edge
clrn  in  1  asynchronous active-low reset
offhook  in  1  level; 1 = handset lifted
digit_valid  in  1  one-cycle strobe; digit is valid this cycle
digit  in  4  BCD dialed digit
answer  in  1  level; 1 = callee has answered
card  in  1  card-present indication (billing block read)
cut  in  1  forced disconnect request from the billing block
on  out  1  1 = line connected (billing input)
category  out  2  01 local, 10 long-distance, 11 special, 00 none
dial_tone  out  1  1 in DIAL_TONE
ring_back  out  1  1 in RINGING
busy_tone  out  1  1 in BUSY

Behaviour:
- Decided: reset clrn, asynchronous, active-low; clock clk_4Hz.
- All state and outputs are registered on posedge clk_4Hz.
- Reset values: state=IDLE, on=0, category=00, all tones 0, digit count=0, tick counter=0.

States and transitions:
- IDLE: offhook=1 -> DIAL_TONE; counter cleared.
- DIAL_TONE, on a valid digit:
  - digit 0 -> category=10;
  - digit 1 -> category=11;
  - digits 2-9 -> category=01;
  - in all three cases count=1, counter cleared, -> DIALING.
- DIAL_TONE, no digit: counter reaching DIGIT_TICKS -> BUSY.
- DIALING:
  - each valid digit increments the count and clears the counter;
  - a digit value >9 is ignored: no count change, no timeout reset;
  - number complete when count equals the target length for the latched category (NUM_LOCAL / NUM_LONG / NUM_SPECIAL).
  - On completion: card=1 or category=11 -> RINGING; card=0 and category!=11 -> BUSY.
  - Counter reaching DIGIT_TICKS -> BUSY.
- RINGING: answer=1 -> CONNECTED; counter reaching RING_TICKS -> BUSY.
- CONNECTED:
  - on=1;
  - cut=1 -> BUSY;
  - card=0 with category!=11 -> BUSY;
  - on is 0 from the cycle after the exit condition is sampled;
  - answer going low -> BUSY.
- BUSY: on=0, busy_tone=1; stays until offhook=0.

Global rules:
- offhook=0 sampled in any state -> IDLE next edge; category cleared; overrides all other conditions.
- Priority within CONNECTED: offhook=0 > cut > card removal > answer low.
- category is latched at the first digit and held constant through RINGING and CONNECTED. It is cleared only in IDLE and stays held in BUSY.
- Latency: answer sampled at edge N -> on=1 after edge N.
- A digit strobe on the completing edge is consumed; later strobes before RINGING are impossible. Strobes in RINGING, CONNECTED or BUSY are ignored.
- Counter saturates; it is cleared on every state change.
- Reset mid-call drops on immediately (asynchronous).

Decomposition:
- Shared package: state encoding (IDLE, DIAL_TONE, DIALING, RINGING, CONNECTED, BUSY) and category constants (CAT_NONE=00, CAT_LOCAL=01, CAT_LONG=10, CAT_SPECIAL=11). The billing block reuses the category constants.
- One sub-module: digit_collector, which holds the digit count, first-digit classification and inter-digit timeout, and outputs complete / timeout / category.
- Main FSM stays in exchange_ctrl.

Test Plan:
1. Reset, offhook=1, card=1, dial 0,1,0,6,2,3,4,5,6,7,8 (11 digits), answer=1 three ticks later -> category=10; ring_back for 3 ticks; on=1 one edge after answer; on=0 one edge after offhook=0; category=00.
2. card=1, dial 5,5,5,1,2,3,4, hold answer=0 -> RINGING for exactly 20 ticks, then busy_tone=1, on never 1; offhook=0 -> IDLE.
3. card=0, dial 1,1,0, answer=1 -> category=11, on=1. card=0, dial 2 plus 6 more digits -> category=01, BUSY at completion, on=0.
4. Connected local call, assert cut=1 for one tick -> on=0 next edge, busy_tone=1, category stays 01 until hang-up.
5. offhook=1, no digits for 40 ticks -> BUSY. Retry: 2,3 then a 40-tick gap -> BUSY. Digit 4'hA during DIALING -> count unchanged.
6. Connected long-distance call, pulse clrn low -> on=0, category=00 asynchronously, without waiting for a clock edge. Same scenario with card=0 instead of clrn -> on=0 after next edge, busy_tone=1.
